// File: rtl/seg7_page_scheduler.sv
// -----------------------------------------------------------------------------
// seg7_page_scheduler
//
// Rotates the 7-segment display through up to four stored 16-bit pages.
// Software loads page bytes, a dwell time (ms) and a control word through
// the processor bus. When enabled, the block periodically requests bus
// mastership and writes the current page into the display registers at
// DispBaseAddr (left byte) and DispBaseAddr+1 (right byte).
//
// Register window (write-only, offsets from CfgBaseAddr):
//   +0..+7 : page p left byte at +2p, right byte at +2p+1
//   +8     : control, bit0 = enable, bits[2:1] = last page index
//   +9     : dwell in ms (0 behaves as 1)
//
// Ports:
//   CLK          in   system clock
//   RESET        in   asynchronous active-low reset
//   BUS_DATA     in   processor write data
//   BUS_ADDR     in   processor address
//   BUS_WE       in   processor write strobe
//   BUS_GNT      in   arbiter grant
//   BUS_REQ      out  bus mastership request
//   BUS_ADDR_OUT out  address driven while granted (0 when not writing)
//   BUS_DATA_OUT out  data driven while granted (0 when not writing)
//   BUS_WE_OUT   out  write strobe driven while granted
//   CUR_PAGE     out  index of the page most recently written or pending
// -----------------------------------------------------------------------------
module seg7_page_scheduler #(
  parameter logic [7:0] CfgBaseAddr  = 8'hD8,
  parameter logic [7:0] DispBaseAddr = 8'hD0,
  parameter int         TickMax      = 99999
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       BUS_GNT,
  output logic       BUS_REQ,
  output logic [7:0] BUS_ADDR_OUT,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_WE_OUT,
  output logic [1:0] CUR_PAGE
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WR_L,
    WR_R,
    WAIT
  } stateT;

  localparam logic [16:0] tickLast  = 17'(TickMax);
  localparam logic [7:0]  dispRight = 8'(DispBaseAddr + 8'd1);

  stateT       state;
  logic [16:0] preCnt;
  logic        msTick;

  logic [7:0]  pageL [4];
  logic [7:0]  pageR [4];
  logic        enable;
  logic [1:0]  lastPage;
  logic [7:0]  dwell;
  logic [7:0]  dwellCnt;
  logic [1:0]  curPage;

  logic        busReq;
  logic        busWeOut;
  logic [7:0]  busAddrOut;
  logic [7:0]  busDataOut;

  logic [7:0]  regOff;
  logic        inWindow;
  logic        cfgWr;
  logic        ctrlWr;
  logic        enNext;
  logic [7:0]  dwellEff;

  // Address decode. The subtraction wraps, so anything below the base lands
  // far outside the 10-byte window. The processor is locked out while this
  // block owns the bus, judged by the registered request it is driving.
  assign regOff   = BUS_ADDR - CfgBaseAddr;
  assign inWindow = (regOff < 8'd10);
  assign cfgWr    = BUS_WE && inWindow && !busReq;
  assign ctrlWr   = cfgWr && (regOff == 8'd8);

  // IDLE looks at the enable value being written this edge so that an
  // enabling write starts the rotation without an extra cycle; it also
  // catches an enable that landed while the FSM was dropping back to IDLE.
  assign enNext   = ctrlWr ? BUS_DATA[0] : enable;
  assign dwellEff = (dwell == 8'd0) ? 8'd1 : dwell;
  assign msTick   = (preCnt == tickLast);

  // Free-running ms prescaler, independent of the scheduler state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      preCnt <= '0;
    end else if (msTick) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + 17'd1;
    end
  end

  // Configuration registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 4; i++) begin
        pageL[i] <= '0;
        pageR[i] <= '0;
      end
      enable   <= 1'b0;
      lastPage <= '0;
      dwell    <= '0;
    end else if (cfgWr) begin
      if (regOff == 8'd8) begin
        enable   <= BUS_DATA[0];
        lastPage <= BUS_DATA[2:1];
      end else if (regOff == 8'd9) begin
        dwell <= BUS_DATA;
      end else if (regOff[0]) begin
        pageR[regOff[2:1]] <= BUS_DATA;
      end else begin
        pageL[regOff[2:1]] <= BUS_DATA;
      end
    end
  end

  // Scheduler FSM. Bus outputs are registered from the current state, so
  // they trail the state by one clock: the cycle spent in WR_L is followed
  // by the left-byte write on the bus, and likewise for WR_R. Page bytes
  // are read in that state cycle, so edits show on the page's next write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      curPage    <= '0;
      dwellCnt   <= '0;
      busReq     <= 1'b0;
      busWeOut   <= 1'b0;
      busAddrOut <= '0;
      busDataOut <= '0;
    end else begin
      busReq     <= (state == REQ) || (state == WR_L) || (state == WR_R);
      busWeOut   <= (state == WR_L) || (state == WR_R);
      busAddrOut <= '0;
      busDataOut <= '0;
      if (state == WR_L) begin
        busAddrOut <= DispBaseAddr;
        busDataOut <= pageL[curPage];
      end else if (state == WR_R) begin
        busAddrOut <= dispRight;
        busDataOut <= pageR[curPage];
      end

      case (state)
        IDLE: begin
          if (enNext) begin
            state   <= REQ;
            curPage <= '0;
          end
        end
        REQ: begin
          if (!enable) begin
            state <= IDLE;
          end else if (BUS_GNT) begin
            state <= WR_L;
          end
        end
        // Grant is held by the arbiter until the request drops, so it is
        // not re-checked once the write pair has started.
        WR_L: begin
          state <= WR_R;
        end
        WR_R: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            state    <= WAIT;
            dwellCnt <= '0;
          end
        end
        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (dwellCnt >= dwellEff) begin
            // A shrunken last index wraps an out-of-range page back to 0.
            curPage <= (curPage >= lastPage) ? 2'd0 : curPage + 2'd1;
            state   <= REQ;
          end else if (msTick) begin
            dwellCnt <= dwellCnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign BUS_REQ      = busReq;
  assign BUS_WE_OUT   = busWeOut;
  assign BUS_ADDR_OUT = busAddrOut;
  assign BUS_DATA_OUT = busDataOut;
  assign CUR_PAGE     = curPage;

endmodule

// File: tb/tb_seg7_page_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg7_page_scheduler
//
// Bench for seg7_page_scheduler with a 10-clock ms tick. A monitor logs every
// display write (cycle, address, data); each test task drives configuration
// traffic and compares the logged writes against the page rotation expected
// from the register contents: pair k shows page k mod (last+1), left byte
// at 0xD0 then right byte at 0xD1 on the next cycle, pairs one dwell apart.
// -----------------------------------------------------------------------------
module tb_seg7_page_scheduler;

  localparam int         T     = 9;
  localparam int         TICK  = T + 1;
  localparam logic [7:0] CFG   = 8'hD8;
  localparam logic [7:0] DISP  = 8'hD0;
  localparam logic [7:0] DISPR = 8'hD1;
  localparam logic [7:0] CTRL  = 8'hE0;
  localparam logic [7:0] DWELL = 8'hE1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] BUS_DATA = 8'h00;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic       BUS_GNT = 1'b0;
  logic       BUS_REQ;
  logic [7:0] BUS_ADDR_OUT;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_WE_OUT;
  logic [1:0] CUR_PAGE;

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  int idleViol = 0;

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } wrT;
  wrT wq[$];

  logic [7:0] pgL [4];
  logic [7:0] pgR [4];

  seg7_page_scheduler #(
    .CfgBaseAddr (CFG),
    .DispBaseAddr(DISP),
    .TickMax     (T)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BUS_DATA    (BUS_DATA),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_WE      (BUS_WE),
    .BUS_GNT     (BUS_GNT),
    .BUS_REQ     (BUS_REQ),
    .BUS_ADDR_OUT(BUS_ADDR_OUT),
    .BUS_DATA_OUT(BUS_DATA_OUT),
    .BUS_WE_OUT  (BUS_WE_OUT),
    .CUR_PAGE    (CUR_PAGE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RESET) begin
      if (BUS_WE_OUT === 1'b1) begin
        wq.push_back('{cyc, BUS_ADDR_OUT, BUS_DATA_OUT});
      end else if (BUS_ADDR_OUT !== 8'h00 || BUS_DATA_OUT !== 8'h00) begin
        idleViol++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nextCyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a;
    BUS_DATA = d;
    BUS_WE   = 1'b1;
    nextCyc();
    BUS_WE   = 1'b0;
    BUS_ADDR = 8'h00;
    BUS_DATA = 8'h00;
  endtask

  task automatic randomPages();
    for (int p = 0; p < 4; p++) begin
      pgL[p] = 8'($urandom);
      pgR[p] = 8'($urandom);
    end
  endtask

  task automatic loadPages(input int dwell);
    for (int p = 0; p < 4; p++) begin
      busWrite(8'(int'(CFG) + 2 * p), pgL[p]);
      busWrite(8'(int'(CFG) + 2 * p + 1), pgR[p]);
    end
    busWrite(DWELL, 8'(dwell));
  endtask

  task automatic stopRotation();
    BUS_GNT = 1'b1;
    for (int i = 0; i < 200 && BUS_REQ === 1'b1; i++) nextCyc();
    busWrite(CTRL, 8'h00);
    repeat (40) nextCyc();
  endtask

  function automatic logic [7:0] ctrlByte(input int last, input bit en);
    logic [1:0] l;
    l = 2'(last);
    return {5'd0, l, en};
  endfunction

  task automatic test_reset();
    #1 RESET = 1'b0;
    repeat (3) nextCyc();
    nCmp++; if (BUS_REQ !== 1'b0) begin nFail++; $display("FAIL reset BUS_REQ: got %b want 0", BUS_REQ); end
    nCmp++; if (BUS_WE_OUT !== 1'b0) begin nFail++; $display("FAIL reset BUS_WE_OUT: got %b want 0", BUS_WE_OUT); end
    nCmp++; if (BUS_ADDR_OUT !== 8'h00) begin nFail++; $display("FAIL reset BUS_ADDR_OUT: got %h want 00", BUS_ADDR_OUT); end
    nCmp++; if (BUS_DATA_OUT !== 8'h00) begin nFail++; $display("FAIL reset BUS_DATA_OUT: got %h want 00", BUS_DATA_OUT); end
    nCmp++; if (CUR_PAGE !== 2'd0) begin nFail++; $display("FAIL reset CUR_PAGE: got %0d want 0", CUR_PAGE); end
    RESET = 1'b1;
    randomPages();
    loadPages(1);
    busWrite(CTRL, 8'h06);
    repeat (30) nextCyc();
    nCmp++; if (BUS_REQ !== 1'b0 || wq.size() != 0) begin
      nFail++; $display("FAIL reset idle: BUS_REQ %b writes %0d, want 0 and 0", BUS_REQ, wq.size());
    end
    wq.delete();
  endtask

  task automatic test_rotation(input string name, input int dwell, input int last, input bit fixedPages);
    int t0, nPairs, dEff, budget, p, lo, hi, gap;
    if (fixedPages) begin
      pgL[0] = 8'h12; pgR[0] = 8'h34; pgL[1] = 8'h56; pgR[1] = 8'h78;
      pgL[2] = 8'h9A; pgR[2] = 8'hBC; pgL[3] = 8'hDE; pgR[3] = 8'hF0;
    end else begin
      randomPages();
    end
    BUS_GNT = 1'b1;
    loadPages(dwell);
    wq.delete();
    busWrite(CTRL, ctrlByte(last, 1'b1));
    t0     = cyc;
    nPairs = 2 * (last + 1) + 1;
    dEff   = (dwell == 0) ? 1 : dwell;
    budget = nPairs * (dEff + 2) * TICK + 50;
    // Dwell spans dEff ticks give or take one, plus WAIT entry, the advance,
    // the grant edge and the left-write cycle.
    lo = (dEff - 1) * TICK + 5;
    hi = (dEff + 1) * TICK + 4;
    for (int i = 0; i < budget && wq.size() < 2 * nPairs; i++) nextCyc();
    nCmp++;
    if (wq.size() < 2 * nPairs) begin
      nFail++; $display("FAIL %s write count: got %0d want %0d", name, wq.size(), 2 * nPairs);
    end else begin
      nCmp++; if (wq[0].c != t0 + 2) begin
        nFail++; $display("FAIL %s first write latency: got cycle %0d want %0d", name, wq[0].c, t0 + 2);
      end
      for (int k = 0; k < nPairs; k++) begin
        p = k % (last + 1);
        nCmp++; if (wq[2*k].a !== DISP || wq[2*k].d !== pgL[p]) begin
          nFail++; $display("FAIL %s pair %0d left: got %h<-%h want %h<-%h", name, k, wq[2*k].a, wq[2*k].d, DISP, pgL[p]);
        end
        nCmp++; if (wq[2*k+1].a !== DISPR || wq[2*k+1].d !== pgR[p] || wq[2*k+1].c != wq[2*k].c + 1) begin
          nFail++; $display("FAIL %s pair %0d right: got %h<-%h at +%0d want %h<-%h at +1", name, k,
                            wq[2*k+1].a, wq[2*k+1].d, wq[2*k+1].c - wq[2*k].c, DISPR, pgR[p]);
        end
        if (k > 0) begin
          gap = wq[2*k].c - wq[2*k-2].c;
          nCmp++; if (gap < lo || gap > hi) begin
            nFail++; $display("FAIL %s pair %0d spacing: got %0d clocks want %0d..%0d", name, k, gap, lo, hi);
          end
        end
      end
    end
    stopRotation();
    wq.delete();
  endtask

  task automatic test_grant_delay();
    int t0, c, bad;
    randomPages();
    BUS_GNT = 1'b0;
    loadPages(2);
    wq.delete();
    busWrite(CTRL, ctrlByte(0, 1'b1));
    t0 = cyc;
    nextCyc();
    nCmp++; if (BUS_REQ !== 1'b1) begin nFail++; $display("FAIL grant req rise: got %b want 1", BUS_REQ); end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      nextCyc();
      if (BUS_REQ !== 1'b1 || BUS_WE_OUT !== 1'b0) bad++;
    end
    nCmp++; if (bad != 0 || wq.size() != 0) begin
      nFail++; $display("FAIL grant hold: got %0d bad cycles, %0d writes want 0, 0", bad, wq.size());
    end
    BUS_GNT = 1'b1;
    c = cyc;
    nextCyc();
    nextCyc();
    nextCyc();
    nCmp++; if (BUS_REQ !== 1'b1) begin nFail++; $display("FAIL grant req during right: got %b want 1", BUS_REQ); end
    nextCyc();
    nCmp++; if (BUS_REQ !== 1'b0) begin nFail++; $display("FAIL grant req fall: got %b want 0", BUS_REQ); end
    BUS_GNT = 1'b0;
    nCmp++;
    if (wq.size() != 2) begin
      nFail++; $display("FAIL grant write count: got %0d want 2", wq.size());
    end else if (wq[0].c != c + 2 || wq[0].a !== DISP || wq[0].d !== pgL[0] ||
                 wq[1].c != c + 3 || wq[1].a !== DISPR || wq[1].d !== pgR[0]) begin
      nFail++; $display("FAIL grant pair: got %h<-%h @%0d, %h<-%h @%0d want %h<-%h @%0d, %h<-%h @%0d",
                        wq[0].a, wq[0].d, wq[0].c, wq[1].a, wq[1].d, wq[1].c,
                        DISP, pgL[0], c + 2, DISPR, pgR[0], c + 3);
    end
    stopRotation();
    wq.delete();
  endtask

  task automatic test_disable_req();
    int bad;
    randomPages();
    BUS_GNT = 1'b0;
    loadPages(1);
    wq.delete();
    busWrite(CTRL, ctrlByte(0, 1'b1));
    busWrite(CTRL, 8'h00);
    for (int i = 0; i < 5 && BUS_REQ === 1'b1; i++) nextCyc();
    nCmp++; if (BUS_REQ !== 1'b0) begin nFail++; $display("FAIL disable_req fall: got %b want 0", BUS_REQ); end
    BUS_GNT = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      nextCyc();
      if (BUS_REQ !== 1'b0) bad++;
    end
    nCmp++; if (bad != 0 || wq.size() != 0) begin
      nFail++; $display("FAIL disable_req quiet: got %0d req cycles, %0d writes want 0, 0", bad, wq.size());
    end
    wq.delete();
  endtask

  task automatic test_disable_wrl();
    randomPages();
    BUS_GNT = 1'b1;
    loadPages(1);
    wq.delete();
    busWrite(CTRL, ctrlByte(1, 1'b1));
    busWrite(CTRL, 8'h00);
    repeat (40) nextCyc();
    nCmp++;
    if (wq.size() != 2) begin
      nFail++; $display("FAIL disable_wrl count: got %0d writes want 2", wq.size());
    end else begin
      nCmp++; if (wq[0].a !== DISP || wq[0].d !== pgL[0] || wq[1].a !== DISPR || wq[1].d !== pgR[0]) begin
        nFail++; $display("FAIL disable_wrl pair: got %h<-%h %h<-%h want %h<-%h %h<-%h",
                          wq[0].a, wq[0].d, wq[1].a, wq[1].d, DISP, pgL[0], DISPR, pgR[0]);
      end
    end
    nCmp++; if (BUS_REQ !== 1'b0) begin nFail++; $display("FAIL disable_wrl idle req: got %b want 0", BUS_REQ); end
    wq.delete();
  endtask

  task automatic test_wrap_shrink();
    int gap;
    randomPages();
    BUS_GNT = 1'b1;
    loadPages(3);
    wq.delete();
    busWrite(CTRL, ctrlByte(3, 1'b1));
    for (int i = 0; i < 300 && wq.size() < 8; i++) nextCyc();
    for (int i = 0; i < 10 && BUS_REQ === 1'b1; i++) nextCyc();
    nCmp++; if (CUR_PAGE !== 2'd3) begin nFail++; $display("FAIL wrap cur_page before shrink: got %0d want 3", CUR_PAGE); end
    busWrite(CTRL, ctrlByte(1, 1'b1));
    for (int i = 0; i < 200 && wq.size() < 12; i++) nextCyc();
    nCmp++;
    if (wq.size() < 12) begin
      nFail++; $display("FAIL wrap write count: got %0d want 12", wq.size());
    end else begin
      nCmp++; if (wq[8].d !== pgL[0] || wq[9].d !== pgR[0]) begin
        nFail++; $display("FAIL wrap page after shrink: got %h/%h want %h/%h", wq[8].d, wq[9].d, pgL[0], pgR[0]);
      end
      nCmp++; if (wq[10].d !== pgL[1] || wq[11].d !== pgR[1]) begin
        nFail++; $display("FAIL wrap next page: got %h/%h want %h/%h", wq[10].d, wq[11].d, pgL[1], pgR[1]);
      end
      gap = wq[8].c - wq[6].c;
      nCmp++; if (gap < 2 * TICK + 5) begin
        nFail++; $display("FAIL wrap no restart spacing: got %0d clocks want >= %0d", gap, 2 * TICK + 5);
      end
    end
    stopRotation();
    wq.delete();
  endtask

  task automatic test_reset_midwrite();
    logic [7:0] nl, nr;
    randomPages();
    BUS_GNT = 1'b1;
    loadPages(1);
    wq.delete();
    busWrite(CTRL, ctrlByte(1, 1'b1));
    for (int i = 0; i < 200 && wq.size() < 3; i++) nextCyc();
    RESET = 1'b0;
    #1;
    nCmp++; if (BUS_WE_OUT !== 1'b0 || BUS_REQ !== 1'b0) begin
      nFail++; $display("FAIL midreset strobes: got we %b req %b want 0 0", BUS_WE_OUT, BUS_REQ);
    end
    nCmp++; if (BUS_ADDR_OUT !== 8'h00 || BUS_DATA_OUT !== 8'h00) begin
      nFail++; $display("FAIL midreset bus: got %h/%h want 00/00", BUS_ADDR_OUT, BUS_DATA_OUT);
    end
    nCmp++; if (CUR_PAGE !== 2'd0) begin nFail++; $display("FAIL midreset cur_page: got %0d want 0", CUR_PAGE); end
    repeat (2) nextCyc();
    RESET = 1'b1;
    wq.delete();
    nl = 8'($urandom);
    nr = 8'($urandom);
    busWrite(CFG, nl);
    busWrite(8'(CFG + 8'd1), nr);
    busWrite(DWELL, 8'd1);
    busWrite(DISP, 8'hA5);
    busWrite(8'hE2, 8'h01);
    busWrite(CTRL, 8'h06);
    repeat (30) nextCyc();
    nCmp++; if (BUS_REQ !== 1'b0 || wq.size() != 0) begin
      nFail++; $display("FAIL midreset ignore traffic: got req %b writes %0d want 0 0", BUS_REQ, wq.size());
    end
    busWrite(CTRL, ctrlByte(1, 1'b1));
    for (int i = 0; i < 100 && wq.size() < 4; i++) nextCyc();
    nCmp++;
    if (wq.size() < 4) begin
      nFail++; $display("FAIL midreset restart count: got %0d want 4", wq.size());
    end else begin
      nCmp++; if (wq[0].d !== nl || wq[1].d !== nr) begin
        nFail++; $display("FAIL midreset new page0: got %h/%h want %h/%h", wq[0].d, wq[1].d, nl, nr);
      end
      nCmp++; if (wq[2].d !== 8'h00 || wq[3].d !== 8'h00) begin
        nFail++; $display("FAIL midreset cleared page1: got %h/%h want 00/00", wq[2].d, wq[3].d);
      end
    end
    stopRotation();
    wq.delete();
  endtask

  task automatic test_idle_outputs();
    nCmp++; if (idleViol != 0) begin
      nFail++; $display("FAIL idle bus outputs: got %0d nonzero idle cycles want 0", idleViol);
    end
  endtask

  initial begin
    test_reset();
    test_rotation("basic", 1, 1, 1'b1);
    test_rotation("dwell0", 0, 1, 1'b0);
    test_rotation("dwell3", 3, 2, 1'b0);
    test_rotation("rand", int'($urandom_range(1, 2)), int'($urandom_range(0, 3)), 1'b0);
    test_grant_delay();
    test_disable_req();
    test_disable_wrl();
    test_wrap_shrink();
    test_reset_midwrite();
    test_idle_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
